// File: rtl/transmit_pkg.sv
// transmit_pkg: shared states, status codes and frame-length helper for the NV serial transmitter.
// Defining TRANSMIT_PARITY_EN adds one even-parity bit to every frame.
package transmit_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, DONE = 2'd2, GAP = 2'd3} state_e;
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_SEND = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;
  localparam logic [1:0] ST_GAP  = 2'b11;
`ifdef TRANSMIT_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif
  function automatic int frame_bits(input int data_w);
    return data_w + (PARITY_EN ? 3 : 2);
  endfunction
endpackage

// File: rtl/transmit_bit_tick.sv
// transmit_bit_tick: bit-period divider, pulses tick_o on the last cycle of every CLK_DIV-cycle period.
module transmit_bit_tick #(
  parameter int CLK_DIV = 50
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);
  localparam int CW = $clog2(CLK_DIV);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    tick_o = en_i && cnt_q == CW'(CLK_DIV - 1);
    cnt_d = clr_i ? '0 : tick_o ? '0 : en_i ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/transmit.sv
// transmit: NV controller serial frame transmitter (start bit, MSB-first payload, optional parity, stop bit).
// Parity insertion is selected by TRANSMIT_PARITY_EN through transmit_pkg.
module transmit
  import transmit_pkg::*;
#(
  parameter int                DATA_W     = 16,
  parameter logic [DATA_W-1:0] FRAME_WORD = DATA_W'(32'hA5C3),
  parameter int                CLK_DIV    = 50,
  parameter int                GAP_BITS   = 4
) (
  input  logic       clkp,
  input  logic       clkn,
  input  logic       reset,
  input  logic       clikcs,
  input  logic       start,
  output logic [1:0] status,
  output logic       data_out
);
  localparam int FB = frame_bits(DATA_W);
  localparam int BW = $clog2((FB > GAP_BITS ? FB : GAP_BITS) + 1);
  state_e            state_q;
  logic [1:0]        status_q;
  logic              dout_q;
  logic [BW-1:0]     bit_q;
  logic [BW-1:0]     nb;
  logic [DATA_W-1:0] shift_q;
  logic              par_q;
  logic              tick, frame_end, gap_end, load, nxt_bit;
  logic              unused_clkn;
  assign unused_clkn = clkn;
  transmit_bit_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk_i (clkp),
    .rst_i (reset),
    .en_i  (state_q == SEND || state_q == GAP),
    .clr_i (state_q == IDLE || state_q == DONE),
    .tick_o(tick)
  );
  // bit_q indexes frame bits in SEND and gap bit periods in GAP
  always_comb begin
    nb        = bit_q + 1'b1;
    frame_end = tick && bit_q == BW'(FB - 1);
    gap_end   = tick && bit_q == BW'(GAP_BITS - 1);
    load      = start && (state_q == IDLE || (state_q == GAP && gap_end));
    nxt_bit   = nb <= BW'(DATA_W) ? shift_q[DATA_W-1] :
                (PARITY_EN && nb == BW'(DATA_W + 1)) ? par_q : 1'b1;
  end
  always_ff @(posedge clkp or posedge reset)
    if (reset) begin
      state_q  <= IDLE;
      status_q <= ST_IDLE;
      dout_q   <= 1'b1;
      bit_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
    end else if (load) begin
      state_q  <= SEND;
      status_q <= ST_SEND;
      dout_q   <= 1'b0;
      bit_q    <= '0;
      shift_q  <= FRAME_WORD;
      par_q    <= 1'b0;
    end else begin
      case (state_q)
        SEND:
          if (frame_end) begin
            state_q  <= clikcs ? GAP : DONE;
            status_q <= clikcs ? ST_GAP : ST_DONE;
            dout_q   <= 1'b1;
            bit_q    <= '0;
          end else if (tick) begin
            bit_q  <= nb;
            dout_q <= nxt_bit;
            if (nb <= BW'(DATA_W)) begin
              shift_q <= {shift_q[DATA_W-2:0], 1'b0};
              par_q   <= par_q ^ shift_q[DATA_W-1];
            end
          end
        DONE:
          if (!start) begin
            state_q  <= IDLE;
            status_q <= ST_IDLE;
          end
        GAP:
          if (gap_end) begin
            state_q  <= IDLE;
            status_q <= ST_IDLE;
            bit_q    <= '0;
          end else if (tick) bit_q <= nb;
        default: ;
      endcase
    end
  assign status   = status_q;
  assign data_out = dout_q;
endmodule

// File: tb/tb_transmit.sv
// tb_transmit: random and directed stimulus checked every cycle against a frame-level reference model.
module tb_transmit;
  localparam int DW = 16;
  localparam int CD = 50;
  localparam int GB = 4;
  localparam logic [DW-1:0] FW = 16'hA5C3;
`ifdef TRANSMIT_PARITY_EN
  localparam int PB = 1;
  localparam int EXP_CYC = 950;
`else
  localparam int PB = 0;
  localparam int EXP_CYC = 900;
`endif
  localparam int FB = DW + 2 + PB;
  logic clk = 1'b0, rst = 1'b1, start = 1'b1, clikcs = 1'b0;
  logic clkn;
  logic [1:0] status;
  logic data_out;
  int checks = 0, failures = 0;
  int ph = 0, k = 0;
  assign clkn = ~clk;
  always #5 clk = ~clk;
  transmit #(.DATA_W(DW), .FRAME_WORD(FW), .CLK_DIV(CD), .GAP_BITS(GB)) dut (
    .clkp(clk), .clkn(clkn), .reset(rst), .clikcs(clikcs), .start(start),
    .status(status), .data_out(data_out)
  );
  function automatic logic exp_bit(input int j);
    if (j == 0) return 1'b0;
    if (j <= DW) return FW[DW-j];
    if (PB == 1 && j == DW + 1) return ^FW;
    return 1'b1;
  endfunction
  // reference: phase (0 idle,1 send,2 done,3 gap) plus cycles elapsed in that phase
  always @(posedge clk or posedge rst)
    if (rst) begin
      ph <= 0;
      k  <= 0;
    end else begin
      case (ph)
        0: if (start) begin ph <= 1; k <= 0; end
        1: if (k + 1 == FB * CD) begin ph <= clikcs ? 3 : 2; k <= 0; end else k <= k + 1;
        2: if (!start) ph <= 0;
        default: if (k + 1 == GB * CD) begin ph <= start ? 1 : 0; k <= 0; end else k <= k + 1;
      endcase
    end
  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", name, got, exp, $time);
    end
  endtask
  task automatic wait_st(input logic [1:0] s, input int lim, input string name);
    int n = 0;
    while (status !== s && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk(name, int'(status), int'(s));
  endtask
  task automatic capture(input string tag);
    logic smp [FB*CD];
    logic [DW-1:0] pay;
    int n = 0;
    wait_st(2'b01, 3000, {tag, "_send_wait"});
    while (status === 2'b01 && n < 2000) begin
      if (n < FB * CD) smp[n] = data_out;
      @(negedge clk);
      n++;
    end
    chk({tag, "_len"}, n, EXP_CYC);
    chk({tag, "_startbit"}, int'(smp[CD/2]), 0);
    for (int j = 1; j <= DW; j++) pay[DW-j] = smp[j*CD+CD/2];
    chk({tag, "_payload"}, int'(pay), 'hA5C3);
`ifdef TRANSMIT_PARITY_EN
    chk({tag, "_parity"}, int'(smp[(DW+1)*CD+CD/2]), 0);
`endif
    chk({tag, "_stopbit"}, int'(smp[(FB-1)*CD+CD/2]), 1);
  endtask
  initial begin
    int n;
    fork
      forever begin
        logic [2:0] e;
        @(negedge clk);
        e = {2'(ph), (ph == 1) ? exp_bit(k / CD) : 1'b1};
        checks++;
        if ({status, data_out} !== e) begin
          failures++;
          $display("FAIL cycle t=%0t got status=%b data_out=%b exp status=%b data_out=%b",
                   $time, status, data_out, e[2:1], e[0]);
        end
      end
    join_none
    repeat (16000) @(negedge clk);
    chk("reset_status", int'(status), 0);
    chk("reset_dout", int'(data_out), 1);
    rst = 1'b0;
    capture("f1");
    chk("done_entry", int'(status), 2);
    repeat (100) @(negedge clk);
    chk("done_hold", int'(status), 2);
    start = 1'b0;
    @(negedge clk);
    chk("drop_idle", int'(status), 0);
    start = 1'b1;
    capture("f2");
    repeat (200) @(negedge clk);
    chk("one_frame_only", int'(status), 2);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    clikcs = 1'b1;
    capture("r1");
    chk("gap_entry", int'(status), 3);
    n = 0;
    while (status === 2'b11 && n < 1000) begin @(negedge clk); n++; end
    chk("gap_len", n, 200);
    capture("r2");
    start = 1'b0;
    n = 0;
    while (status === 2'b11 && n < 1000) begin @(negedge clk); n++; end
    chk("gap_len2", n, 200);
    chk("gap_to_idle", int'(status), 0);
    clikcs = 1'b0;
    start = 1'b1;
    wait_st(2'b01, 100, "mid_send_wait");
    repeat (400) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_status", int'(status), 0);
    chk("async_rst_dout", int'(data_out), 1);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    chk("idle_after_rst", int'(status), 0);
    start = 1'b1;
    capture("f3");
    for (int i = 0; i < 40; i++) begin
      start = 1'($urandom_range(0, 1));
      clikcs = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) begin
        #1 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
      repeat ($urandom_range(1, 1200)) @(negedge clk);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
